// File: rtl/chip.sv
// chip -- keyed byte accumulator with AXI-Stream in/out.
//
// Input frames arrive as (key, value) beat pairs on s_axis; only byte 0 of
// each beat is used. Each value is added, with saturation, to the bin named
// by its key (1..BINS). A beat carrying tlast ends the frame, after which
// the BINS accumulators are streamed out on m_axis, one beat per bin, and
// then cleared for the next frame.
//
// Ports
//   aclk           clock, everything on the rising edge
//   aresetn        asynchronous active-low reset
//   s_axis_tvalid  input beat valid
//   s_axis_tready  input beat accepted (high while collecting a frame)
//   s_axis_tdata   input payload, byte 0 = key or value
//   s_axis_tlast   last beat of the input frame
//   m_axis_tvalid  output beat valid
//   m_axis_tready  downstream ready
//   m_axis_tdata   output payload: [ACC_WIDTH-1:0] = count, [39:32] = bin number
//   m_axis_tlast   last beat of the output vector
//
// state   | meaning
// --------+-----------------------------------------------
// ST_KEY  | waiting for a key beat
// ST_VAL  | waiting for the value beat of the held key
// ST_EMIT | streaming the accumulator vector, input stalled

module chip #(
  parameter int DATA_WIDTH = 512,
  parameter int BINS       = 12,
  parameter int ACC_WIDTH  = 32
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tlast,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tlast
);

  localparam int IW = (BINS > 1) ? $clog2(BINS) : 1;

  typedef enum logic [1:0] {ST_KEY, ST_VAL, ST_EMIT} state_t;

  state_t                 state;
  logic [7:0]             key;
  logic [ACC_WIDTH-1:0]   acc [BINS];
  logic [IW-1:0]          idx;
  logic                   s_ready;
  logic                   m_valid;
  logic                   m_last;

  logic                   s_xfer;
  logic [7:0]             din;
  logic [ACC_WIDTH-1:0]   acc_sel;
  logic [ACC_WIDTH:0]     sum;
  logic [ACC_WIDTH-1:0]   acc_sat;
  logic [DATA_WIDTH-1:0]  m_data;
  logic                   unused_tdata;

  assign s_xfer       = s_axis_tvalid & s_ready;
  assign din          = s_axis_tdata[7:0];
  assign unused_tdata = ^s_axis_tdata[DATA_WIDTH-1:8];

  // Out-of-range keys match no bin, so acc_sel stays 0 and no bin is written.
  always_comb begin
    acc_sel = '0;
    for (int i = 0; i < BINS; i++) begin
      if (key == 8'(i + 1)) acc_sel = acc[i];
    end
    sum     = {1'b0, acc_sel} + (ACC_WIDTH + 1)'(din);
    acc_sat = sum[ACC_WIDTH] ? '1 : sum[ACC_WIDTH-1:0];
  end

  // Payload is driven straight from the held accumulators; they cannot change
  // while in ST_EMIT, so the beat stays stable across back-pressure.
  always_comb begin
    m_data = '0;
    if (m_valid) begin
      m_data[ACC_WIDTH-1:0] = acc[idx];
      m_data[39:32]         = 8'(idx) + 8'd1;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state   <= ST_KEY;
      key     <= '0;
      idx     <= '0;
      s_ready <= 1'b0;
      m_valid <= 1'b0;
      m_last  <= 1'b0;
      for (int i = 0; i < BINS; i++) acc[i] <= '0;
    end else begin
      case (state)
        ST_KEY: begin
          s_ready <= 1'b1;
          if (s_xfer) begin
            if (s_axis_tlast) begin
              // a key with tlast has no value to go with it: drop it
              state   <= ST_EMIT;
              s_ready <= 1'b0;
              m_valid <= 1'b1;
              m_last  <= (BINS == 1);
              idx     <= '0;
            end else begin
              key   <= din;
              state <= ST_VAL;
            end
          end
        end
        ST_VAL: begin
          s_ready <= 1'b1;
          if (s_xfer) begin
            for (int i = 0; i < BINS; i++) begin
              if (key == 8'(i + 1)) acc[i] <= acc_sat;
            end
            if (s_axis_tlast) begin
              state   <= ST_EMIT;
              s_ready <= 1'b0;
              m_valid <= 1'b1;
              m_last  <= (BINS == 1);
              idx     <= '0;
            end else begin
              state <= ST_KEY;
            end
          end
        end
        ST_EMIT: begin
          if (m_valid && m_axis_tready) begin
            if (idx == IW'(BINS - 1)) begin
              for (int i = 0; i < BINS; i++) acc[i] <= '0;
              state   <= ST_KEY;
              s_ready <= 1'b1;
              m_valid <= 1'b0;
              m_last  <= 1'b0;
              idx     <= '0;
            end else begin
              idx    <= idx + 1'b1;
              m_last <= (idx == IW'(BINS - 2));
            end
          end
        end
        default: state <= ST_KEY;
      endcase
    end
  end

  assign s_axis_tready = s_ready;
  assign m_axis_tvalid = m_valid;
  assign m_axis_tdata  = m_data;
  assign m_axis_tlast  = m_last;

endmodule

// File: tb/tb_chip.sv
// Testbench for chip: directed frames, expected vectors queued as frames are
// issued, a forked monitor pops and compares each output beat as it transfers.
// ACC_WIDTH is set to 8 so saturation is reachable in a short run.

module tb_chip;

  localparam int DW   = 512;
  localparam int BINS = 12;
  localparam int AW   = 8;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          s_tvalid = 1'b0;
  logic [DW-1:0] s_tdata = '0;
  logic          s_tlast = 1'b0;
  logic          m_tready = 1'b0;
  logic          s_axis_tready;
  logic          m_axis_tvalid;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tlast;

  chip #(.DATA_WIDTH(DW), .BINS(BINS), .ACC_WIDTH(AW)) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tdata  (s_tdata),
    .s_axis_tlast  (s_tlast),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tlast  (m_axis_tlast)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  beat_t q[$];
  int    n_vec = 0;
  int    n_err = 0;
  int    popped = 0;
  int    stall_mode = 0;
  int    expv [BINS];

  // downstream ready, changed 2 time units after the rising edge
  int cyc = 0;
  always @(posedge aclk) begin
    #2;
    cyc = cyc + 1;
    case (stall_mode)
      0: m_tready = 1'b1;
      1: m_tready = (cyc % 8) >= 2;
      default: m_tready = 1'b0;
    endcase
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_vec();
    beat_t b;
    for (int i = 0; i < BINS; i++) begin
      b.data = '0;
      b.data[7:0] = expv[i][7:0];
      b.data[39:32] = 8'(i + 1);
      b.last = (i == BINS - 1);
      q.push_back(b);
    end
  endtask

  task automatic set_exp(input int v);
    for (int i = 0; i < BINS; i++) expv[i] = v;
  endtask

  // Checks at the falling edge, for the beat that transfers on the next rise.
  task automatic monitor();
    beat_t         e;
    logic          stalled = 1'b0;
    logic [DW-1:0] held_d = '0;
    logic          held_l = 1'b0;
    forever begin
      @(negedge aclk);
      if (!aresetn) begin
        stalled = 1'b0;
      end else begin
        if (stalled) begin
          n_vec++;
          if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== held_d || m_axis_tlast !== held_l) begin
            n_err++;
            $display("FAIL stall_hold: tvalid=%b tdata[39:0]=%h tlast=%b held tdata[39:0]=%h tlast=%b",
                     m_axis_tvalid, m_axis_tdata[39:0], m_axis_tlast, held_d[39:0], held_l);
          end
        end
        if (m_axis_tvalid) check("s_ready_during_emit", 64'(s_axis_tready), 64'd0);
        if (m_axis_tvalid && m_tready) begin
          n_vec++;
          if (q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_beat: tdata[39:0]=%h tlast=%b with nothing expected",
                     m_axis_tdata[39:0], m_axis_tlast);
          end else begin
            e = q.pop_front();
            if (m_axis_tdata !== e.data || m_axis_tlast !== e.last) begin
              n_err++;
              $display("FAIL out_beat %0d: got tdata[39:0]=%h tlast=%b expected tdata[39:0]=%h tlast=%b",
                       popped, m_axis_tdata[39:0], m_axis_tlast, e.data[39:0], e.last);
            end
            popped++;
          end
          stalled = 1'b0;
        end else if (m_axis_tvalid) begin
          stalled = 1'b1;
          held_d = m_axis_tdata;
          held_l = m_axis_tlast;
        end else begin
          stalled = 1'b0;
        end
      end
    end
  endtask

  task automatic send_beat(input logic [7:0] b, input logic last);
    int budget;
    @(negedge aclk);
    s_tvalid = 1'b1;
    s_tdata = '0;
    s_tdata[7:0] = b;
    s_tdata[15:8] = 8'hA5;
    s_tlast = last;
    budget = 0;
    while (!s_axis_tready && budget < 3000) begin
      @(negedge aclk);
      budget++;
    end
    if (!s_axis_tready) begin
      check("s_ready_timeout", 64'(s_axis_tready), 64'd1);
      s_tvalid = 1'b0;
      return;
    end
    @(posedge aclk);
    if (last) begin
      #1;
      check("tvalid_after_last", 64'(m_axis_tvalid), 64'd1);
      check("s_ready_low_in_emit", 64'(s_axis_tready), 64'd0);
      s_tvalid = 1'b0;
      s_tlast = 1'b0;
    end
  endtask

  task automatic send_pair(input logic [7:0] k, input logic [7:0] v, input logic last);
    send_beat(k, 1'b0);
    send_beat(v, last);
  endtask

  task automatic send_frame12(input logic [7:0] v);
    for (int k = 1; k <= BINS; k++) send_pair(8'(k), v, k == BINS);
  endtask

  task automatic drain();
    int budget = 0;
    while (q.size() != 0 && budget < 3000) begin
      @(posedge aclk);
      budget++;
    end
    check("drain_queue_left", 64'(q.size()), 64'd0);
  endtask

  initial begin
    int base;
    int budget;
    fork
      monitor();
    join_none

    // reset state
    repeat (3) @(negedge aclk);
    check("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("rst_tlast", 64'(m_axis_tlast), 64'd0);
    check("rst_tdata", m_axis_tdata[63:0], 64'd0);
    check("rst_s_ready", 64'(s_axis_tready), 64'd0);
    aresetn = 1'b1;
    @(posedge aclk); #1;
    check("s_ready_after_rst", 64'(s_axis_tready), 64'd1);

    // keys 1..12, value 0x9E
    set_exp(158); push_vec();
    send_frame12(8'h9E);
    drain();

    // three back-to-back frames
    for (int f = 0; f < 3; f++) begin
      set_exp(158); push_vec();
      send_frame12(8'h9E);
    end
    drain();

    // downstream stalls 2 low / 6 high
    stall_mode = 1;
    set_exp(158); push_vec();
    send_frame12(8'h9E);
    drain();
    stall_mode = 0;

    // repeated key, out-of-range keys
    set_exp(0); expv[2] = 30; push_vec();
    send_pair(8'd3, 8'd10, 1'b0);
    send_pair(8'd3, 8'd20, 1'b0);
    send_pair(8'd13, 8'd99, 1'b0);
    send_pair(8'd0, 8'd5, 1'b1);
    drain();

    // zero value, frame ended on a key beat
    set_exp(0); expv[1] = 7; push_vec();
    send_pair(8'd2, 8'd7, 1'b0);
    send_pair(8'd6, 8'd0, 1'b0);
    send_beat(8'd4, 1'b1);
    drain();

    // saturation at 255
    set_exp(0); expv[4] = 255; push_vec();
    for (int n = 0; n < 300; n++) send_pair(8'd5, 8'hFF, n == 299);
    drain();

    // reset in the middle of the vector, after beat 4 transfers
    base = popped;
    set_exp(8'h11); push_vec();
    send_frame12(8'h11);
    budget = 0;
    do begin
      @(posedge aclk);
      budget++;
    end while (popped < base + 4 && budget < 500);
    check("reached_beat4", 64'(popped >= base + 4), 64'd1);
    #1 aresetn = 1'b0;
    #1;
    q.delete();
    check("midrst_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("midrst_tlast", 64'(m_axis_tlast), 64'd0);
    check("midrst_tdata", m_axis_tdata[63:0], 64'd0);
    check("midrst_s_ready", 64'(s_axis_tready), 64'd0);
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    @(posedge aclk); #1;
    check("s_ready_after_midrst", 64'(s_axis_tready), 64'd1);
    check("tvalid_after_midrst", 64'(m_axis_tvalid), 64'd0);
    repeat (4) @(posedge aclk);
    set_exp(158); push_vec();
    send_frame12(8'h9E);
    drain();

    repeat (5) @(posedge aclk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
